// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU clock-enable controller.
// Holds the mode FSM encoding and the button status bundle.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  localparam int DB_CNT_DEF = 16;
  localparam int DB_W_DEF   = 5;
  localparam int DIV_W_DEF  = 8;
  localparam int STEP_W     = 16;

  typedef struct packed {
    logic stable;
    logic press;
  } btn_t;

endpackage

// File: rtl/btn_debounce.sv
// Counter debouncer: a level must differ for DB_CNT cycles to be taken.
// press is a registered one-cycle pulse on the rising edge of stable.
module btn_debounce #(
  parameter int DB_CNT = 16,
  parameter int DB_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic stable,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CNT - 1);

  logic [DB_W-1:0] cnt;
  logic            stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
      if (in != stable) begin
        if (cnt == LAST) begin
          stable <= in;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gen_sync.sv
// Multi-flop synchronizer for asynchronous single-bit inputs.
// Active-high asynchronous reset loads RST_VAL into every stage.
module gen_sync #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= {STAGES{RST_VAL}};
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable sequencer for the 8-bit core: manual step, run, halt.
// Define STEP_CNT_EN to build the 16-bit issued-pulse counter.
module cpu_clk_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEF,
  parameter int DB_W   = DB_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_btn_async,
  input  logic             run_btn_async,
  input  logic             cpu_hlt,
  input  logic [DIV_W-1:0] run_div,
  output logic             clk_en,
  output logic             run_mode,
  output logic             halted,
  output logic [15:0]      step_cnt
);

  logic rst;
  logic step_sync;
  logic run_sync;
  btn_t step_b;
  btn_t run_b;
  logic step_press;
  logic run_press;

  assign rst = ~rst_n;

  gen_sync #(.STAGES(3), .RST_VAL(1'b0)) u_sync_step (
    .clk (clk),
    .rst (rst),
    .d   (step_btn_async),
    .q   (step_sync)
  );

  gen_sync #(.STAGES(3), .RST_VAL(1'b0)) u_sync_run (
    .clk (clk),
    .rst (rst),
    .d   (run_btn_async),
    .q   (run_sync)
  );

  btn_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (step_sync),
    .stable (step_b.stable),
    .press  (step_b.press)
  );

  btn_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_run (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (run_sync),
    .stable (run_b.stable),
    .press  (run_b.press)
  );

  // a press only counts while its level is still held
  assign step_press = step_b.press & step_b.stable;
  assign run_press  = run_b.press & run_b.stable;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             en_q;
  logic             en_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_MANUAL;
      div   <= '0;
      en_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      en_q  <= en_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (cpu_hlt) begin
      state_nxt = ST_HALT;
    end else begin
      unique case (state)
        ST_MANUAL: if (run_press) state_nxt = ST_RUN;
        ST_RUN:    if (run_press) state_nxt = ST_MANUAL;
        ST_HALT:   state_nxt = ST_HALT;
        default:   state_nxt = ST_MANUAL;
      endcase
    end
  end

  // divider idles at zero outside RUN so each entry starts a full period
  always_comb begin
    en_nxt  = 1'b0;
    div_nxt = div;
    unique case (state)
      ST_MANUAL: begin
        div_nxt = '0;
        en_nxt  = step_press & ~run_press;
      end
      ST_RUN: begin
        if (run_press) begin
          div_nxt = '0;
        end else if (div == run_div) begin
          en_nxt  = 1'b1;
          div_nxt = '0;
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      ST_HALT: begin
        div_nxt = '0;
      end
      default: begin
        div_nxt = '0;
      end
    endcase
    if (cpu_hlt) en_nxt = 1'b0;
  end

  assign clk_en   = en_q & ~cpu_hlt;
  assign run_mode = (state == ST_RUN);
  assign halted   = (state == ST_HALT);

`ifdef STEP_CNT_EN
  logic [STEP_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clk_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign step_cnt = cnt;
`else
  assign step_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: event-level model plus directed button scenarios.
// Build with STEP_CNT_EN defined to also exercise the pulse counter.
module tb_cpu_clk_ctrl;

  localparam int DB   = 4;
  localparam int DW   = 3;
  localparam int DIVW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            step_btn = 1'b0;
  logic            run_btn = 1'b0;
  logic            cpu_hlt = 1'b0;
  logic [DIVW-1:0] run_div = '0;
  logic            clk_en;
  logic            run_mode;
  logic            halted;
  logic [15:0]     step_cnt;

  cpu_clk_ctrl #(.DB_CNT(DB), .DB_W(DW), .DIV_W(DIVW)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .step_btn_async (step_btn),
    .run_btn_async  (run_btn),
    .cpu_hlt        (cpu_hlt),
    .run_div        (run_div),
    .clk_en         (clk_en),
    .run_mode       (run_mode),
    .halted         (halted),
    .step_cnt       (step_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: mode 0=manual 1=run 2=halt; buttons seen through a 3-cycle delay
  // and a DB-sample agreement window, presses one cycle after the level flips
  int          t = 0;
  int          tref = 0;
  int          mode = 0;
  bit          m_en = 0;
  bit [15:0]   m_cnt = 0;
  bit [2:0]    sq [2];
  bit [DB-1:0] win [2];
  bit          stb [2];
  bit          rose [2];
  bit          prs [2];
  bit          raw [2];
  bit          dbin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; tref = 0; mode = 0; m_en = 0; m_cnt = 0;
      for (int b = 0; b < 2; b++) begin
        sq[b] = '0; win[b] = '0; stb[b] = 0; rose[b] = 0; prs[b] = 0;
      end
    end else begin
`ifdef STEP_CNT_EN
      if (m_en && !cpu_hlt) m_cnt = m_cnt + 16'd1;
`endif
      t++;
      if (cpu_hlt || mode == 2) begin
        mode = 2; m_en = 0;
      end else if (mode == 0) begin
        if (prs[1]) begin mode = 1; tref = t; m_en = 0; end
        else m_en = prs[0];
      end else begin
        if (prs[1]) begin mode = 0; m_en = 0; end
        else m_en = ((t - tref) % (int'(run_div) + 1)) == 0;
      end
      raw[0] = step_btn;
      raw[1] = run_btn;
      for (int b = 0; b < 2; b++) begin
        prs[b]  = rose[b];
        rose[b] = 0;
        dbin    = sq[b][2];
        sq[b]   = {sq[b][1:0], raw[b]};
        win[b]  = {win[b][DB-2:0], dbin};
        if (win[b] == {DB{~stb[b]}}) begin
          stb[b]  = ~stb[b];
          rose[b] = stb[b];
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("clk_en", {31'b0, clk_en}, {31'b0, m_en & ~cpu_hlt});
      chk("run_mode", {31'b0, run_mode}, {31'b0, mode == 1});
      chk("halted", {31'b0, halted}, {31'b0, mode == 2});
      chk("step_cnt", {16'b0, step_cnt}, {16'b0, m_cnt});
    end
  end

  int pulses = 0;
  always @(posedge clk) begin
    #1;
    if (rst_n && clk_en) pulses++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic push(input bit which, input int hold);
    @(negedge clk);
    if (which) run_btn = 1'b1; else step_btn = 1'b1;
    cyc(hold);
    if (which) run_btn = 1'b0; else step_btn = 1'b0;
    cyc(hold);
  endtask

  task automatic wait_pulse(output int k, input int lim);
    k = 0;
    while (k < lim) begin
      @(posedge clk);
      #1;
      k++;
      if (clk_en) break;
    end
  endtask

  int  k;
  int  p0;
  bit  st_seen;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_clk_en", {31'b0, clk_en}, 32'd0);
    chk("rst_run_mode", {31'b0, run_mode}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_step_cnt", {16'b0, step_cnt}, 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    // single manual step: 3 sync + 4 debounce + 1 edge + 1 fsm
    p0 = pulses;
    step_btn = 1'b1;
    wait_pulse(k, 30);
    chk("step_latency", k, 32'd9);
    cyc(20);
    step_btn = 1'b0;
    cyc(20);
    chk("step_once", pulses - p0, 32'd1);
    chk("step_run_mode", {31'b0, run_mode}, 32'd0);
    chk("step_halted", {31'b0, halted}, 32'd0);

    // short glitch is filtered
    p0 = pulses;
    st_seen = 0;
    @(negedge clk);
    step_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0;
    repeat (15) begin
      @(negedge clk);
      st_seen |= u_dut.u_db_step.stable;
    end
    chk("glitch_stable", {31'b0, st_seen}, 32'd0);
    chk("glitch_pulses", pulses - p0, 32'd0);

    // run mode with period 4
    run_div = 8'd3;
    push(1'b1, 10);
    chk("run_enter", {31'b0, run_mode}, 32'd1);
    wait_pulse(k, 20);
    wait_pulse(k, 20);
    chk("run_gap", k, 32'd4);
    wait_pulse(k, 20);
    chk("run_gap2", k, 32'd4);
    push(1'b1, 10);
    chk("run_exit", {31'b0, run_mode}, 32'd0);
    p0 = pulses;
    cyc(20);
    chk("run_exit_quiet", pulses - p0, 32'd0);

    // both buttons together: run wins, step dropped
    p0 = pulses;
    @(negedge clk);
    step_btn = 1'b1;
    run_btn  = 1'b1;
    cyc(11);
    chk("both_no_step", pulses - p0, 32'd0);
    chk("both_run", {31'b0, run_mode}, 32'd1);
    step_btn = 1'b0;
    run_btn  = 1'b0;
    cyc(10);
    push(1'b1, 10);
    chk("both_exit", {31'b0, run_mode}, 32'd0);

    // run every cycle, then halt
    run_div = 8'd0;
    push(1'b1, 10);
    chk("fast_run", {31'b0, run_mode}, 32'd1);
    @(posedge clk);
    #1;
    chk("fast_en", {31'b0, clk_en}, 32'd1);
    @(negedge clk);
    cpu_hlt = 1'b1;
    #1;
    chk("hlt_gate", {31'b0, clk_en}, 32'd0);
    @(posedge clk);
    #1;
    chk("hlt_halted", {31'b0, halted}, 32'd1);
    chk("hlt_run_mode", {31'b0, run_mode}, 32'd0);
    @(negedge clk);
    cpu_hlt = 1'b0;
    p0 = pulses;
    push(1'b0, 10);
    push(1'b1, 10);
    chk("hlt_sticky", {31'b0, halted}, 32'd1);
    chk("hlt_quiet", pulses - p0, 32'd0);

`ifdef STEP_CNT_EN
    // counter wrap over 70000 pulses, then reset mid-run
    do_reset();
    run_div = 8'd0;
    run_btn = 1'b1;
    k = 0;
    for (int i = 0; i < 71000 && k < 70000; i++) begin
      @(posedge clk);
      #1;
      if (clk_en) k++;
    end
    chk("wrap_pulses", k, 32'd70000);
    @(posedge clk);
    #1;
    chk("wrap_cnt", {16'b0, step_cnt}, 32'd4464);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", {16'b0, step_cnt}, 32'd0);
    chk("mid_rst_run", {31'b0, run_mode}, 32'd0);
    chk("mid_rst_en", {31'b0, clk_en}, 32'd0);
    run_btn = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
`else
    do_reset();
    chk("cnt_tied", {16'b0, step_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Clock-enable controller for the 8-bit computer core. It sequences when the CPU datapath advances.
- Takes raw asynchronous front-panel buttons (STEP, RUN) and the CPU halt flag. It produces a single-cycle clock-enable pulse: one per manual step in manual mode, or at a programmable rate in run mode.
- Each button is synchronized by an existing gen_sync instance, then debounced, before it reaches the mode state machine.

Parameters:
- DB_CNT, 16, consecutive stable cycles required before a debounced button changes state (min 2).
- DB_W, 5, width of debounce counter; must satisfy 2**DB_W > DB_CNT.
- DIV_W, 8, width of run-mode rate divider.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- step_btn_async  in  1  raw STEP button, asynchronous, active-high.
- run_btn_async  in  1  raw RUN/STOP toggle button, asynchronous, active-high.
- cpu_hlt  in  1  CPU HLT flag, synchronous to clk.
- run_div  in  DIV_W  run-mode period minus one, in clk cycles.
- clk_en  out  1  single-cycle CPU advance pulse.
- run_mode  out  1  1 while in RUN state.
- halted  out  1  1 while in HALT state.
- step_cnt  out  16  count of issued clk_en pulses.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; FSM = MANUAL; debouncers stable=0, count=0; divider=0.
- Synchronizer stage:
  - Each button passes through gen_sync with RST_VAL=0.
  - Its active-high rst is driven by ~rst_n.
  - Adds 3 cycles of latency.
- Debounce (per button):
  - If the sync value differs from the stable value, the counter increments; otherwise the counter clears.
  - When count == DB_CNT-1 with the input still differing, stable takes the sync value and the counter clears.
  - press = 1-cycle pulse on the 0->1 transition of stable.
  - Glitches shorter than DB_CNT cycles are discarded.
- FSM states: MANUAL, RUN, HALT.
- MANUAL:
  - run_press -> RUN; divider cleared.
  - Else step_press -> clk_en=1 in the following cycle (registered).
  - RUN has priority over STEP when both press in the same cycle; that step is dropped.
- RUN:
  - Divider counts 0..run_div. On divider == run_div, clk_en=1 for 1 cycle and the divider reloads 0.
  - run_div=0 -> clk_en every cycle.
  - run_div is sampled live; if changed below the current count, the divider wraps at 2**DIV_W and continues.
  - step_press is ignored.
  - run_press -> MANUAL; no clk_en in the transition cycle.
- HALT:
  - Entered from any state the cycle after cpu_hlt=1 is sampled.
  - clk_en forced 0 in the same cycle cpu_hlt is high; the hlt gating is combinational on the registered enable.
  - Sticky until rst_n is asserted; both buttons are ignored.
- Outputs: run_mode = (state==RUN); halted = (state==HALT), both registered.
- clk_en never asserts for 2 consecutive cycles in MANUAL.
- Reset mid-operation: immediate return to reset values; any pending pulse is discarded.
- Latency, raw STEP edge to clk_en: 3 (sync) + DB_CNT (debounce) + 1 (edge) + 1 (FSM) cycles.

Optional Feature:
- STEP_CNT_EN defined: step_cnt increments by 1 on every cycle with clk_en=1 and wraps 0xFFFF->0x0000; reset 0.
- Not defined: step_cnt tied to 16'h0000 and no counter flops are inferred.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - FSM state encoding ST_MANUAL=2'd0, ST_RUN=2'd1, ST_HALT=2'd2;
  - default DB_CNT, DIV_W constants.
- One sub-module, btn_debounce (params DB_CNT, DB_W; ports clk, rst_n, in, stable, press).
  - Instantiated twice, each fed from its own gen_sync.

Test Plan:
- DB_CNT=4, reset, STEP held high 20 cycles -> exactly one clk_en pulse, 3+4+1+1=9 cycles after the edge; run_mode=0, halted=0.
- STEP glitch high for 2 cycles -> no clk_en, debounced stable stays 0.
- RUN press, run_div=3 -> run_mode=1, clk_en pulses every 4 cycles; a second RUN press -> run_mode=0, no more pulses.
- RUN mode, run_div=0 -> clk_en=1 every cycle; cpu_hlt=1 in cycle N -> clk_en=0 in cycle N, halted=1 from N+1; later STEP/RUN presses have no effect.
- STEP and RUN debounced in the same cycle from MANUAL -> enters RUN, no manual step pulse.
- With STEP_CNT_EN: 70000 clk_en pulses -> step_cnt=4464 (wrapped); rst_n low mid-run -> step_cnt=0, run_mode=0 immediately.
